// File: rtl/delay_latency_meter.sv
// rtl/delay_latency_meter.sv - marker-based latency meter for a fixed data delay stage
//
// Watches the data entering (iv_ref_data) and leaving (iv_dly_data) a delay stage
// and counts the clock cycles a software-chosen marker byte takes to pass through.
// One measurement per accepted i_start; the result is held until the next one.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start      1-cycle measurement request, accepted only in S_IDLE
//   i_abort      return to S_IDLE from any state, no done/timeout raised
//   iv_marker    marker value, latched on accepted i_start
//   iv_ref_data  data entering the delay stage
//   iv_dly_data  data leaving the delay stage
//   o_busy       high in S_ARM and S_WAIT
//   o_done       1-cycle pulse when ov_latency becomes valid
//   o_timeout    sticky: last measurement timed out
//   ov_latency   measured latency in cycles

module delay_latency_meter #(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] iv_marker,
    input  logic [DATA_W-1:0] iv_ref_data,
    input  logic [DATA_W-1:0] iv_dly_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  ov_latency
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_marker;
    logic [DATA_W-1:0]   w_marker_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    r_latency;
    logic [CNT_W-1:0]    w_latency_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;
    logic                r_busy;
    logic                r_done;
    logic                w_ref_hit;
    logic                w_dly_hit;

    assign w_ref_hit = (iv_ref_data == r_marker);
    assign w_dly_hit = (iv_dly_data == r_marker);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_marker  <= '0;
            r_cnt     <= '0;
            r_latency <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_marker  <= w_marker_nxt;
            r_cnt     <= w_cnt_nxt;
            r_latency <= w_latency_nxt;
            r_timeout <= w_timeout_nxt;
            // Status flags are registered from the next state so they line up
            // exactly with the state they describe.
            r_busy    <= (w_state_nxt == S_ARM) || (w_state_nxt == S_WAIT);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_marker_nxt  = r_marker;
        w_cnt_nxt     = r_cnt;
        w_latency_nxt = r_latency;
        w_timeout_nxt = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_marker_nxt  = iv_marker;
                    w_latency_nxt = '0;
                    w_timeout_nxt = 1'b0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_ARM;
                end
            end
            S_ARM: begin
                if (w_ref_hit) begin
                    if (w_dly_hit) begin
                        // Zero-depth path: marker seen on both sides on one edge.
                        w_latency_nxt = '0;
                        w_state_nxt   = S_DONE;
                    end else begin
                        // Counter holds the cycles elapsed at the next edge.
                        w_cnt_nxt   = LP_ONE;
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Ref-side matches are ignored here: the first marker occurrence wins.
                if (w_dly_hit) begin
                    w_latency_nxt = r_cnt;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_DONE;
                end else if (r_cnt == LP_TIMEOUT) begin
                    w_timeout_nxt = 1'b1;
                    w_latency_nxt = '0;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in S_IDLE; results are kept.
        if (i_abort) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_marker_nxt  = r_marker;
            w_latency_nxt = r_latency;
            w_timeout_nxt = r_timeout;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_timeout  = r_timeout;
    assign ov_latency = r_latency;

endmodule

// File: tb/tb_delay_latency_meter.sv
// tb/tb_delay_latency_meter.sv - directed self-checking bench for delay_latency_meter

module tb_delay_latency_meter;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort_r;
    logic [7:0] marker;
    logic [7:0] ref_d;
    logic [7:0] dly_d;
    logic       busy;
    logic       done;
    logic       tmo;
    logic [7:0] lat;

    int n_checks;
    int n_errors;
    int dly_mode;  // 0 = wire, 1..4 = register stages, 8 = output held at zero

    logic [7:0] pipe [0:3];

    delay_latency_meter #(
        .DATA_W (8),
        .CNT_W  (8),
        .TIMEOUT(255)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_abort    (abort_r),
        .iv_marker  (marker),
        .iv_ref_data(ref_d),
        .iv_dly_data(dly_d),
        .o_busy     (busy),
        .o_done     (done),
        .o_timeout  (tmo),
        .ov_latency (lat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe[0] <= ref_d;
        pipe[1] <= pipe[0];
        pipe[2] <= pipe[1];
        pipe[3] <= pipe[2];
    end

    always_comb begin
        dly_d = 8'h00;
        if (dly_mode == 0)
            dly_d = ref_d;
        else if (dly_mode >= 1 && dly_mode <= 4)
            dly_d = pipe[2'(dly_mode - 1)];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort_r = 1'b0; marker = 8'h00; ref_d = 8'h00; dly_mode = 0;
        idle(3);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL reset_timeout got=%0b exp=0", tmo); end
        n_checks++; if (lat !== 8'h00) begin n_errors++; $display("FAIL reset_latency got=%0h exp=0", lat); end
        rst_n = 1'b1;
        idle(2);
    endtask

    // Start, then drive 0,1,M,3,0... on ref and observe a full measurement.
    task automatic run_measure(input logic [7:0] m, input int stages, input logic [7:0] exp_lat, input string name);
        int         done_cnt;
        logic [7:0] lat_seen;
        done_cnt = 0; lat_seen = 8'hEE;
        dly_mode = stages; ref_d = 8'h00;
        idle(5);
        start = 1'b1; marker = m;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL %s_busy_armed got=%0b exp=1", name, busy); end
        for (int k = 0; k < 16; k++) begin
            case (k)
                0:       ref_d = 8'h00;
                1:       ref_d = 8'h01;
                2:       ref_d = m;
                3:       ref_d = 8'h03;
                default: ref_d = 8'h00;
            endcase
            tick();
            if (done === 1'b1) begin done_cnt++; lat_seen = lat; end
        end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt); end
        n_checks++; if (lat_seen !== exp_lat) begin n_errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat_seen, exp_lat); end
        n_checks++; if (lat !== exp_lat) begin n_errors++; $display("FAIL %s_latency_held got=%0d exp=%0d", name, lat, exp_lat); end
        n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL %s_timeout got=%0b exp=0", name, tmo); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL %s_busy_after got=%0b exp=0", name, busy); end
    endtask

    task automatic test_latencies();
        run_measure(8'hA5, 1, 8'd1, "dly1");
        run_measure(8'h3C, 4, 8'd4, "dly4");
        run_measure(8'h3C, 0, 8'd0, "dly0");
    endtask

    task automatic test_timeout();
        int waited;
        int done_cnt;
        waited = 0; done_cnt = 0;
        dly_mode = 8; ref_d = 8'h00;
        idle(5);
        start = 1'b1; marker = 8'h77;
        tick();
        start = 1'b0; ref_d = 8'h77;
        tick();
        ref_d = 8'h00;
        while (tmo !== 1'b1 && waited < 400) begin
            tick();
            waited++;
            if (done === 1'b1) done_cnt++;
        end
        n_checks++; if (waited !== 255) begin n_errors++; $display("FAIL timeout_cycles got=%0d exp=255", waited); end
        n_checks++; if (tmo !== 1'b1) begin n_errors++; $display("FAIL timeout_flag got=%0b exp=1", tmo); end
        n_checks++; if (done_cnt !== 0) begin n_errors++; $display("FAIL timeout_done got=%0d exp=0", done_cnt); end
        n_checks++; if (lat !== 8'h00) begin n_errors++; $display("FAIL timeout_latency got=%0d exp=0", lat); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL timeout_busy got=%0b exp=0", busy); end
        idle(3);
        n_checks++; if (tmo !== 1'b1) begin n_errors++; $display("FAIL timeout_sticky got=%0b exp=1", tmo); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL timeout_clear got=%0b exp=0", tmo); end
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL timeout_abort_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_start_ignored();
        int         done_cnt;
        logic [7:0] lat_seen;
        done_cnt = 0; lat_seen = 8'hEE;
        dly_mode = 2; ref_d = 8'h00;
        idle(5);
        start = 1'b1; marker = 8'h5A;
        tick();
        start = 1'b0; ref_d = 8'h5A;
        tick();
        start = 1'b1; marker = 8'hFF; ref_d = 8'hFF;
        tick();
        start = 1'b0; marker = 8'h00; ref_d = 8'h00;
        if (done === 1'b1) begin done_cnt++; lat_seen = lat; end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done === 1'b1) begin done_cnt++; lat_seen = lat; end
        end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL ign_start_done got=%0d exp=1", done_cnt); end
        n_checks++; if (lat_seen !== 8'd2) begin n_errors++; $display("FAIL ign_start_latency got=%0d exp=2", lat_seen); end
    endtask

    task automatic test_abort();
        int done_cnt;
        done_cnt = 0;
        // Simultaneous start+abort in idle: nothing starts, held result survives.
        start = 1'b1; abort_r = 1'b1; marker = 8'h11;
        tick();
        start = 1'b0; abort_r = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_start_busy got=%0b exp=0", busy); end
        n_checks++; if (lat !== 8'd2) begin n_errors++; $display("FAIL abort_start_latency got=%0d exp=2", lat); end
        // Abort while armed.
        dly_mode = 0; ref_d = 8'h00;
        start = 1'b1; marker = 8'h11;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_arm_busy got=%0b exp=1", busy); end
        abort_r = 1'b1;
        tick();
        abort_r = 1'b0; ref_d = 8'h11;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_idle_busy got=%0b exp=0", busy); end
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1) done_cnt++;
        end
        ref_d = 8'h00;
        n_checks++; if (done_cnt !== 0) begin n_errors++; $display("FAIL abort_done got=%0d exp=0", done_cnt); end
        n_checks++; if (lat !== 8'd0) begin n_errors++; $display("FAIL abort_latency got=%0d exp=0", lat); end
        n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL abort_timeout got=%0b exp=0", tmo); end
    endtask

    // Marker on ref at two consecutive edges; the first occurrence must win.
    task automatic test_back_to_back(input int stages, input logic [7:0] exp_lat, input string name);
        int         done_cnt;
        logic [7:0] lat_seen;
        done_cnt = 0; lat_seen = 8'hEE;
        dly_mode = stages; ref_d = 8'h00;
        idle(5);
        start = 1'b1; marker = 8'hC3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ref_d = (k == 2 || k == 3) ? 8'hC3 : 8'h00;
            tick();
            if (done === 1'b1) begin done_cnt++; lat_seen = lat; end
        end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL %s_done got=%0d exp=1", name, done_cnt); end
        n_checks++; if (lat_seen !== exp_lat) begin n_errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat_seen, exp_lat); end
    endtask

    task automatic test_reset_mid();
        int done_cnt;
        done_cnt = 0;
        dly_mode = 4; ref_d = 8'h00;
        idle(5);
        start = 1'b1; marker = 8'h3C;
        tick();
        start = 1'b0; ref_d = 8'h3C;
        tick();
        ref_d = 8'h00;
        tick();
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_before got=%0b exp=1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done got=%0b exp=0", done); end
        n_checks++; if (tmo !== 1'b0) begin n_errors++; $display("FAIL rstmid_timeout got=%0b exp=0", tmo); end
        n_checks++; if (lat !== 8'h00) begin n_errors++; $display("FAIL rstmid_latency got=%0d exp=0", lat); end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        n_checks++; if (done_cnt !== 0) begin n_errors++; $display("FAIL rstmid_release_activity got=%0d exp=0", done_cnt); end
        run_measure(8'h3C, 4, 8'd4, "post_rst");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_latencies();
        test_timeout();
        test_start_ignored();
        test_abort();
        test_back_to_back(1, 8'd1, "twice1");
        test_back_to_back(2, 8'd2, "twice2");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
